// File: rtl/async_fifo_pkg.sv
// Shared pointer helpers and default sizes for the single-clock FIFO.
// Pointers are packed as {wrap bit, zero-extended index} in a ptr_t.
package async_fifo_pkg;

  localparam int BITS_DEF = 32;
  localparam int SIZE_DEF = 16;

  typedef logic [31:0] ptr_t;

  function automatic logic ptr_full(input ptr_t w, input ptr_t r);
    return (w[31] != r[31]) && (w[30:0] == r[30:0]);
  endfunction

  function automatic logic ptr_empty(input ptr_t w, input ptr_t r);
    return w == r;
  endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// Simple dual-port register array: one write port, one registered read port.
// Read register clears on reset; the array itself is never cleared.
module async_fifo_mem #(
  parameter int BITS = 32,
  parameter int SIZE = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [$clog2(SIZE)-1:0] wr_addr,
  input  logic [BITS-1:0]         wr_data,
  input  logic                    rd_en,
  input  logic [$clog2(SIZE)-1:0] rd_addr,
  output logic [BITS-1:0]         rd_data
);

  logic [BITS-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/async_fifo_single_clk.sv
// Single-clock FIFO with registered exact full/empty and registered read data.
// Optional almost-full/almost-empty flags: define ASYNC_FIFO_ALMOST_FLAGS_EN.
module async_fifo_single_clk
  import async_fifo_pkg::*;
#(
  parameter int BITS = BITS_DEF,
  parameter int SIZE = SIZE_DEF
`ifdef ASYNC_FIFO_ALMOST_FLAGS_EN
  ,
  parameter int ALMOST_FULL_TH  = SIZE - 2,
  parameter int ALMOST_EMPTY_TH = 2
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p_write_en,
  input  logic [BITS-1:0] p_write_data,
  output logic            p_write_full,
  input  logic            p_read_en,
  output logic [BITS-1:0] p_read_data,
  output logic            p_read_empty
`ifdef ASYNC_FIFO_ALMOST_FLAGS_EN
  ,
  output logic            p_write_almost_full,
  output logic            p_read_almost_empty
`endif
);

  localparam int AW = $clog2(SIZE);

  if (SIZE < 2 || (SIZE & (SIZE - 1)) != 0) begin : g_bad_size
    $fatal(1, "async_fifo_single_clk: SIZE must be a power of two >= 2");
  end

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] wptr_n;
  logic [AW:0] rptr_n;
  logic        wr_acc;
  logic        rd_acc;

  function automatic ptr_t pack(input logic [AW:0] p);
    return {p[AW], 31'(p[AW-1:0])};
  endfunction

  assign wr_acc = p_write_en & ~p_write_full & ~rst;
  assign rd_acc = p_read_en & ~p_read_empty & ~rst;

  assign wptr_n = wptr + {{AW{1'b0}}, wr_acc};
  assign rptr_n = rptr + {{AW{1'b0}}, rd_acc};

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      p_read_empty <= 1'b1;
      p_write_full <= 1'b0;
    end else begin
      wptr         <= wptr_n;
      rptr         <= rptr_n;
      p_read_empty <= ptr_empty(pack(wptr_n), pack(rptr_n));
      p_write_full <= ptr_full(pack(wptr_n), pack(rptr_n));
    end
  end

`ifdef ASYNC_FIFO_ALMOST_FLAGS_EN
  logic [AW:0] occ_n;

  assign occ_n = wptr_n - rptr_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_write_almost_full <= 1'b0;
      p_read_almost_empty <= 1'b1;
    end else begin
      p_write_almost_full <= int'(occ_n) >= ALMOST_FULL_TH;
      p_read_almost_empty <= int'(occ_n) <= ALMOST_EMPTY_TH;
    end
  end
`endif

  async_fifo_mem #(
    .BITS(BITS),
    .SIZE(SIZE)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_acc),
    .wr_addr(wptr[AW-1:0]),
    .wr_data(p_write_data),
    .rd_en  (rd_acc),
    .rd_addr(rptr[AW-1:0]),
    .rd_data(p_read_data)
  );

endmodule

// File: tb/tb_async_fifo_single_clk.sv
// Directed self-checking bench for async_fifo_single_clk (default 32x16).
// Table-driven smoke run plus hand-written multi-cycle corner sequences.
module tb_async_fifo_single_clk;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_write_en;
  logic [31:0] p_write_data;
  logic        p_write_full;
  logic        p_read_en;
  logic [31:0] p_read_data;
  logic        p_read_empty;
`ifdef ASYNC_FIFO_ALMOST_FLAGS_EN
  logic        p_write_almost_full;
  logic        p_read_almost_empty;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  async_fifo_single_clk dut (
    .clk         (clk),
    .rst         (rst),
    .p_write_en  (p_write_en),
    .p_write_data(p_write_data),
    .p_write_full(p_write_full),
    .p_read_en   (p_read_en),
    .p_read_data (p_read_data),
`ifdef ASYNC_FIFO_ALMOST_FLAGS_EN
    .p_write_almost_full(p_write_almost_full),
    .p_read_almost_empty(p_read_almost_empty),
`endif
    .p_read_empty(p_read_empty)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] wd;
    logic [31:0] exp_data;
    logic        exp_empty;
    logic        exp_full;
  } vec_t;

  vec_t tbl[34];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic wr, input logic [31:0] wd, input logic rd);
    p_write_en   = wr;
    p_write_data = wd;
    p_read_en    = rd;
    @(posedge clk);
    #1;
    p_write_en = 1'b0;
    p_read_en  = 1'b0;
  endtask

  task automatic chk_flags(input string name, input logic emp,
                           input logic ful);
    chk({name, "_empty"}, {31'd0, p_read_empty}, {31'd0, emp});
    chk({name, "_full"}, {31'd0, p_write_full}, {31'd0, ful});
  endtask

  logic [31:0] held;

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{1'b1, 1'b0, 32'(i), 32'd0, 1'b0, (i == 15)};
    end
    tbl[16] = '{1'b1, 1'b0, 32'hDEAD, 32'd0, 1'b0, 1'b1};
    for (int i = 0; i < 16; i++) begin
      tbl[17 + i] = '{1'b0, 1'b1, 32'd0, 32'(i), (i == 15), 1'b0};
    end
    tbl[33] = '{1'b0, 1'b1, 32'd0, 32'd15, 1'b1, 1'b0};

    // reset held 3 cycles with both requests active
    rst          = 1'b1;
    p_write_en   = 1'b1;
    p_read_en    = 1'b1;
    p_write_data = 32'h77;
    repeat (3) @(posedge clk);
    #1;
    rst        = 1'b0;
    p_write_en = 1'b0;
    p_read_en  = 1'b0;
    chk_flags("reset", 1'b1, 1'b0);
    chk("reset_data", p_read_data, 32'd0);
    cyc(1'b0, 32'd0, 1'b1);
    chk_flags("reset_nostore", 1'b1, 1'b0);
    chk("reset_nostore_data", p_read_data, 32'd0);

    // smoke table
    for (int i = 0; i < 34; i++) begin
      cyc(tbl[i].wr, tbl[i].wd, tbl[i].rd);
      chk($sformatf("smoke%0d_data", i), p_read_data, tbl[i].exp_data);
      chk_flags($sformatf("smoke%0d", i), tbl[i].exp_empty, tbl[i].exp_full);
    end

    // interleaved: occupancy stays at one after the first write
    cyc(1'b1, 32'h1000, 1'b0);
    chk_flags("il_first", 1'b0, 1'b0);
    for (int i = 1; i < 100; i++) begin
      cyc(1'b1, 32'h1000 + 32'(i), 1'b1);
      chk($sformatf("il%0d_data", i), p_read_data, 32'h1000 + 32'(i - 1));
      chk_flags($sformatf("il%0d", i), 1'b0, 1'b0);
    end
    cyc(1'b0, 32'd0, 1'b1);
    chk("il_last_data", p_read_data, 32'h1063);
    chk_flags("il_drained", 1'b1, 1'b0);

    // wrap: three fill/drain passes from an arbitrary pointer offset
    for (int k = 1; k <= 3; k++) begin
      for (int i = 0; i < 16; i++) begin
        cyc(1'b1, 32'(k * 256 + i), 1'b0);
      end
      chk_flags($sformatf("wrap%0d_filled", k), 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) begin
        cyc(1'b0, 32'd0, 1'b1);
        chk($sformatf("wrap%0d_rd%0d", k, i), p_read_data, 32'(k * 256 + i));
      end
      chk_flags($sformatf("wrap%0d_drained", k), 1'b1, 1'b0);
    end

    // simultaneous write+read at full
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 32'h200 + 32'(i), 1'b0);
    end
    chk_flags("bfull_pre", 1'b0, 1'b1);
    cyc(1'b1, 32'hBEEF, 1'b1);
    chk("bfull_head", p_read_data, 32'h200);
    chk_flags("bfull_post", 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) begin
      cyc(1'b0, 32'd0, 1'b1);
      chk($sformatf("bfull_rd%0d", i), p_read_data, 32'h200 + 32'(i));
    end
    chk_flags("bfull_drained", 1'b1, 1'b0);

    // simultaneous write+read at empty
    held = 32'h20F;
    cyc(1'b1, 32'h55, 1'b1);
    chk("bempty_hold", p_read_data, held);
    chk_flags("bempty_post", 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b1);
    chk("bempty_rd", p_read_data, 32'h55);
    chk_flags("bempty_drained", 1'b1, 1'b0);

    // mid-operation reset with seven entries held
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 32'h300 + 32'(i), 1'b0);
    end
    chk_flags("mid_pre", 1'b0, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 32'h99, 1'b1);
    rst = 1'b0;
    chk_flags("mid_rst", 1'b1, 1'b0);
    chk("mid_rst_data", p_read_data, 32'd0);
    cyc(1'b1, 32'hA5, 1'b0);
    chk_flags("mid_wr", 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b1);
    chk("mid_rd", p_read_data, 32'hA5);
    chk_flags("mid_drained", 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/async_fifo_single_clk.md
Name: async_fifo_single_clk

Overview:
- Single-clock FIFO of SIZE entries, each BITS wide; drop-in replacement for the two-clock `async_fifo` wherever producer and consumer share `clk`.
- Keeps the `async_fifo` port naming (`p_write_*` / `p_read_*`) so benches and integrators can swap it in.
- Full/empty flags are registered and exact; read data is registered.

Parameters:
- BITS, 32, width of each entry.
- SIZE, 16, number of entries; must be a power of two and ≥2. Elaboration error (`$fatal`) otherwise.
- AW, `$clog2(SIZE)`, derived memory address width; not overridable.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- p_write_en  in  1  write request; accepted when `!p_write_full`.
- p_write_data  in  BITS  data stored on an accepted write.
- p_write_full  out  1  registered; 1 = SIZE entries held.
- p_read_en  in  1  read request; accepted when `!p_read_empty`.
- p_read_data  out  BITS  registered; head entry captured on an accepted read.
- p_read_empty  out  1  registered; 1 = zero entries held.

Behaviour:
- State: memory `SIZE×BITS`; `wptr`, `rptr`, each AW+1 bits. The MSB is the wrap bit.
- Accept rules: `wr_acc = p_write_en & !p_write_full`; `rd_acc = p_read_en & !p_read_empty`. Both flags are the registered values from the start of the cycle.
- Rejected requests (write when full, read when empty) change nothing and are not errors.
- On `wr_acc`: `mem[wptr[AW-1:0]] <= p_write_data`; `wptr <= wptr+1`, modulo `2^(AW+1)`.
- On `rd_acc`: `p_read_data <= mem[rptr[AW-1:0]]`; `rptr <= rptr+1`.
  - Latency: data is valid from the edge that accepts the read.
  - `p_read_data` holds its value when no read is accepted.
- Flags computed from the next-state pointers and registered:
  - empty when `wptr_n == rptr_n`.
  - full when the MSBs differ and the low AW bits are equal.
- Flag latency:
  - A write into an empty FIFO drops `p_read_empty` on the next edge.
  - A read from a full FIFO drops `p_write_full` on the next edge.
- Simultaneous accepted write and read:
  - Occupancy unchanged; flags unchanged.
  - The write and the read touch different slots; no bypass is needed.
- Write requested while full, read requested in the same cycle: read accepted, write dropped. Next cycle full=0.
- Read requested while empty, write requested in the same cycle: write accepted, read dropped. Next cycle empty=0, and `p_read_data` is unchanged.
- Wrap-around: pointers roll over naturally; ordering is preserved across any number of wraps.
- Reset (`rst=1` at an edge), including mid-operation:
  - `wptr = rptr = 0`; `p_read_empty = 1`; `p_write_full = 0`; `p_read_data = 0`.
  - Memory contents are not cleared; all prior data is discarded.
  - Requests in the reset cycle are ignored.
- No X may propagate to any output after reset.

Optional Feature:
- Macro: `ASYNC_FIFO_ALMOST_FLAGS_EN`.
- When defined, the block adds:
  - Parameters `ALMOST_FULL_TH` (default SIZE-2) and `ALMOST_EMPTY_TH` (default 2).
  - Outputs `p_write_almost_full` and `p_read_almost_empty`, both registered, both updated with the same latency as full/empty.
  - `p_write_almost_full` = 1 when occupancy ≥ `ALMOST_FULL_TH`.
  - `p_read_almost_empty` = 1 when occupancy ≤ `ALMOST_EMPTY_TH`.
  - Occupancy is `wptr - rptr`, AW+1 bits.
  - Reset values: `p_write_almost_full` = 0, `p_read_almost_empty` = 1.
- When undefined, neither these ports nor these parameters exist, and the rest of the behaviour is identical.

Decomposition:
- Package `async_fifo_pkg`:
  - Function `ptr_full(w, r)`.
  - Function `ptr_empty(w, r)`.
  - Localparam defaults `BITS_DEF = 32`, `SIZE_DEF = 16`.
- One sub-module, `async_fifo_mem`: simple dual-port register array with one write port and one synchronous read port, parameterised by BITS and SIZE.
- Pointer and flag logic stays in the top module.

Test Plan:
- Reset: hold `rst` 3 cycles with `p_write_en = p_read_en = 1` → after release `p_read_empty = 1`, `p_write_full = 0`, `p_read_data = 0`, and no data is stored.
- Smoke: write 0..15 on consecutive cycles → `p_write_full = 1` after the 16th edge. A 17th write (value 0xDEAD) is dropped. Read 16 → `p_read_data` = 0,1,…,15 in order, then `p_read_empty = 1`.
- Interleaved:
  - Write 0x1000+i and read continuously for 100 cycles, starting reads once `empty = 0`.
  - Required: data in order; empty never set after the first fill; full never set.
- Wrap: three passes of fill-16 / drain-16 with distinct values (pass k uses k·0x100+i) → all match and flags are correct each pass.
- Boundary simultaneity:
  - At full, assert write+read → read returns the head, the write is dropped, full clears.
  - At empty, assert write+read → the write is stored, the read is dropped, `p_read_data` is unchanged.
- Mid-operation reset: with 7 entries held, pulse `rst` for 1 cycle → empty = 1. A subsequent write 0xA5 then read returns 0xA5.
